// File: rtl/cache_miss_controller.sv
// cache_miss_controller
//   Sequences an L1 miss through the L2 and, on an L2 miss, main memory,
//   then refills L1 and holds one replay cycle so L1 can re-look-up the line.
//   Drives the l1_miss / l2_miss / cache_busy / mem_stall stall causes.
//
// Optional feature macro: CACHE_MISS_PERF_EN
//   Defined   : l1_miss_count / l2_miss_count are saturating 32-bit counters.
//   Undefined : both counter ports are tied to 0 and no counter flops exist.
module cache_miss_controller #(
    parameter int ADDR_WIDTH       = 32,
    parameter int LINE_OFFSET_BITS = 4,
    parameter int FILL_CYCLES      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  l1_hit,
    output logic                  l2_req,
    output logic [ADDR_WIDTH-1:0] l2_addr,
    input  logic                  l2_ack,
    input  logic                  l2_hit,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    output logic                  l1_fill,
    output logic                  fill_src,
    output logic                  l2_fill,
    output logic                  l1_miss,
    output logic                  l2_miss,
    output logic                  cache_busy,
    output logic                  mem_stall,
    output logic [31:0]           l1_miss_count,
    output logic [31:0]           l2_miss_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_L2_REQ,
        S_MEM_REQ,
        S_FILL,
        S_REPLAY
    } state_t;

    // Down-counter wide enough to hold FILL_CYCLES-1 (at least one bit).
    localparam int CNT_W = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] FILL_LOAD = CNT_W'(FILL_CYCLES - 1);

    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      fill_cnt;
    logic [ADDR_WIDTH-1:0] line_addr;
    logic                  fill_src_q;
    logic                  l2_fill_q;
    logic                  miss_detect;
    logic                  fill_entry;

    // Stores are write-allocate and follow exactly the load miss flow, so the
    // direction of the access does not influence sequencing.
    logic unused_req_write;
    assign unused_req_write = req_write;

    // Gated by rst_n so the combinational miss flag stays low while reset is
    // held, even with a pending miss on the request port.
    assign miss_detect = rst_n && req_valid && !l1_hit;
    assign fill_entry  = (state_next == S_FILL) && (state != S_FILL);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic; request inputs are only looked at in IDLE, acks only
    // in their own state.
    always_comb begin
        // NOTE: default assigned first so no path through the case leaves
        // state_next unassigned, which would infer a latch.
        state_next = state;
        case (state)
            S_IDLE:    if (miss_detect) state_next = S_L2_REQ;
            S_L2_REQ:  if (l2_ack)      state_next = l2_hit ? S_FILL : S_MEM_REQ;
            S_MEM_REQ: if (mem_ack)     state_next = S_FILL;
            S_FILL:    if (fill_cnt == '0) state_next = S_REPLAY;
            S_REPLAY:  state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Miss address capture, fill counter, fill source and the L2 write pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_addr  <= '0;
            fill_cnt   <= '0;
            fill_src_q <= 1'b0;
            l2_fill_q  <= 1'b0;
        end else begin
            l2_fill_q <= 1'b0;
            if (state == S_IDLE && miss_detect)
                line_addr <= {req_addr[ADDR_WIDTH-1:LINE_OFFSET_BITS],
                              {LINE_OFFSET_BITS{1'b0}}};
            else if (state == S_REPLAY)
                line_addr <= '0;

            if (fill_entry) begin
                fill_cnt   <= FILL_LOAD;
                fill_src_q <= (state == S_MEM_REQ);
                l2_fill_q  <= (state == S_MEM_REQ);
            end else if (state == S_FILL && fill_cnt != '0) begin
                fill_cnt <= fill_cnt - 1'b1;
            end
        end
    end

    assign l2_req     = (state == S_L2_REQ);
    assign mem_req    = (state == S_MEM_REQ);
    assign l2_addr    = line_addr;
    assign mem_addr   = line_addr;
    assign l1_fill    = (state == S_FILL);
    assign cache_busy = (state == S_FILL);
    assign mem_stall  = (state == S_REPLAY);
    assign fill_src   = fill_src_q;
    assign l2_fill    = l2_fill_q;
    assign l1_miss    = ((state == S_IDLE) && miss_detect) ||
                        (state == S_L2_REQ) || (state == S_MEM_REQ);
    assign l2_miss    = (state == S_MEM_REQ);

`ifdef CACHE_MISS_PERF_EN
    logic [31:0] l1_cnt_q;
    logic [31:0] l2_cnt_q;

    // Saturating miss counters, stepped on IDLE->L2_REQ and L2_REQ->MEM_REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l1_cnt_q <= '0;
            l2_cnt_q <= '0;
        end else begin
            if (state == S_IDLE && state_next == S_L2_REQ && l1_cnt_q != 32'hFFFF_FFFF)
                l1_cnt_q <= l1_cnt_q + 32'd1;
            if (state == S_L2_REQ && state_next == S_MEM_REQ && l2_cnt_q != 32'hFFFF_FFFF)
                l2_cnt_q <= l2_cnt_q + 32'd1;
        end
    end

    assign l1_miss_count = l1_cnt_q;
    assign l2_miss_count = l2_cnt_q;
`else
    assign l1_miss_count = '0;
    assign l2_miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_miss_controller.sv
// Directed self-checking bench for cache_miss_controller.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge. Output flags are packed into one vector for compact checks:
//   [8] l2_req [7] mem_req [6] l1_fill [5] fill_src [4] l2_fill
//   [3] l1_miss [2] l2_miss [1] cache_busy [0] mem_stall
module tb_cache_miss_controller;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr  = '0;
    logic        l1_hit    = 1'b0;
    logic        l2_ack    = 1'b0;
    logic        l2_hit    = 1'b0;
    logic        mem_ack   = 1'b0;
    logic        l2_req, mem_req, l1_fill, fill_src, l2_fill;
    logic        l1_miss, l2_miss, cache_busy, mem_stall;
    logic [31:0] l2_addr, mem_addr, l1_miss_count, l2_miss_count;
    logic [8:0]  outs;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    localparam logic [8:0] O_NONE     = 9'b0_0000_0000;
    localparam logic [8:0] O_MISS     = 9'b0_0000_1000;
    localparam logic [8:0] O_L2       = 9'b1_0000_1000;
    localparam logic [8:0] O_MEM      = 9'b0_1000_1100;
    localparam logic [8:0] O_FILL_L2  = 9'b0_0100_0010;
    localparam logic [8:0] O_REPLAY   = 9'b0_0000_0001;
    localparam logic [8:0] O_FILL_M1  = 9'b0_0111_0010;
    localparam logic [8:0] O_FILL_M2  = 9'b0_0110_0010;
    localparam logic [8:0] SRC        = 9'b0_0010_0000;

    cache_miss_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .l1_hit        (l1_hit),
        .l2_req        (l2_req),
        .l2_addr       (l2_addr),
        .l2_ack        (l2_ack),
        .l2_hit        (l2_hit),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .l1_fill       (l1_fill),
        .fill_src      (fill_src),
        .l2_fill       (l2_fill),
        .l1_miss       (l1_miss),
        .l2_miss       (l2_miss),
        .cache_busy    (cache_busy),
        .mem_stall     (mem_stall),
        .l1_miss_count (l1_miss_count),
        .l2_miss_count (l2_miss_count)
    );

    assign outs = {l2_req, mem_req, l1_fill, fill_src, l2_fill,
                   l1_miss, l2_miss, cache_busy, mem_stall};

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef CACHE_MISS_PERF_EN
        return 32'(n);
`else
        return (n > 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input string tag, input logic [8:0] exp);
        @(negedge clk);
        check(tag, {23'b0, outs}, {23'b0, exp});
    endtask

    initial begin
        // Reset held with a pending miss: nothing may assert.
        req_valid = 1'b1; l1_hit = 1'b0; req_addr = 32'h0000_1234;
        #2 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample("reset_outs", O_NONE);
            check("reset_l2_addr", l2_addr, 32'h0);
            check("reset_l1_cnt", l1_miss_count, 32'h0);
        end
        tick(); rst_n = 1'b1;
        sample("first_miss_after_release", O_MISS);
        // Same-cycle ack (k=1) L2 hit; request inputs ignored meanwhile.
        tick(); l2_ack = 1'b1; l2_hit = 1'b1;
        sample("k1_l2_req", O_L2);
        check("k1_l2_addr", l2_addr, 32'h0000_1230);
        tick(); l2_ack = 1'b0; l2_hit = 1'b0;
        sample("k1_fill1", O_FILL_L2);
        tick(); req_valid = 1'b0;
        sample("k1_fill2", O_FILL_L2);
        tick();
        sample("k1_replay", O_REPLAY);
        tick();
        sample("k1_idle", O_NONE);
        check("k1_idle_addr", l2_addr, 32'h0);

        // L1 hits: no output and no state change.
        req_valid = 1'b1; l1_hit = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sample("hit_idle", O_NONE);
            tick();
        end
        req_valid = 1'b0; l1_hit = 1'b0;

        // L2 hit with ack three cycles after l2_req rises: 7 cycles total.
        req_valid = 1'b1; req_addr = 32'h0000_1234;
        sample("l2hit_miss_c1", O_MISS);
        tick(); req_valid = 1'b0;
        sample("l2hit_req_c2", O_L2);
        check("l2hit_l2_addr", l2_addr, 32'h0000_1230);
        tick();
        sample("l2hit_req_c3", O_L2);
        tick(); l2_ack = 1'b1; l2_hit = 1'b1;
        sample("l2hit_req_c4", O_L2);
        tick(); l2_hit = 1'b0;  // spurious l2_ack in FILL
        sample("l2hit_fill_c5_spurious_ack", O_FILL_L2);
        tick(); l2_ack = 1'b0;
        sample("l2hit_fill_c6", O_FILL_L2);
        tick();
        sample("l2hit_replay_c7", O_REPLAY);
        tick();
        sample("l2hit_idle", O_NONE);

        // Reset pulse clears the counters before the L2 miss case.
        tick(); rst_n = 1'b0;
        sample("pulse_rst_outs", O_NONE);
        check("pulse_rst_l1_cnt", l1_miss_count, 32'h0);
        tick(); rst_n = 1'b1; mem_ack = 1'b1;
        sample("spurious_mem_ack_idle", O_NONE);
        tick(); mem_ack = 1'b0;
        sample("spurious_mem_ack_after", O_NONE);
        check("spurious_mem_ack_addr", mem_addr, 32'h0);

        // L2 miss: ack after 2 cycles, mem_ack 5 cycles later.
        tick(); req_valid = 1'b1; req_addr = 32'hABCD_EF07;
        sample("l2miss_detect", O_MISS);
        tick(); req_addr = 32'h1111_1111;
        sample("l2miss_req1", O_L2);
        check("l2miss_l2_addr", l2_addr, 32'hABCD_EF00);
        tick(); l2_ack = 1'b1; l2_hit = 1'b0;
        sample("l2miss_req2", O_L2);
        tick(); l2_ack = 1'b0;
        sample("l2miss_mem1", O_MEM);
        check("l2miss_mem_addr", mem_addr, 32'hABCD_EF00);
        for (int i = 2; i <= 4; i++) begin
            tick();
            sample("l2miss_mem", O_MEM);
        end
        tick(); mem_ack = 1'b1;
        sample("l2miss_mem5", O_MEM);
        tick(); mem_ack = 1'b0;
        sample("l2miss_fill1_l2_fill", O_FILL_M1);
        tick();
        sample("l2miss_fill2", O_FILL_M2);
        tick();
        sample("l2miss_replay", O_REPLAY | SRC);
        check("l2miss_l1_cnt", l1_miss_count, exp_cnt(1));
        check("l2miss_l2_cnt", l2_miss_count, exp_cnt(1));

        // Back-to-back miss in the first IDLE cycle after REPLAY.
        tick();
        sample("b2b_detect", O_MISS | SRC);
        tick(); l2_ack = 1'b1; l2_hit = 1'b0; req_valid = 1'b0;
        sample("b2b_l2_req", O_L2 | SRC);
        check("b2b_l2_addr", l2_addr, 32'h1111_1110);
        tick(); l2_ack = 1'b0;
        sample("b2b_mem", O_MEM | SRC);
        check("b2b_l1_cnt", l1_miss_count, exp_cnt(2));
        check("b2b_l2_cnt", l2_miss_count, exp_cnt(2));

        // Reset in MEM_REQ abandons the request.
        #2 rst_n = 1'b0; mem_ack = 1'b1;
        #1 check("midrst_outs_drop", {23'b0, outs}, 32'h0);
        check("midrst_addr", mem_addr, 32'h0);
        tick(); rst_n = 1'b1; mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample("midrst_no_fill", O_NONE);
            tick();
        end
        check("midrst_l1_cnt", l1_miss_count, 32'h0);
        check("midrst_l2_cnt", l2_miss_count, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_miss_controller.md
# cache_miss_controller

Sequences L1 misses through the L2 and main memory for the memory stage's load/store port, then refills L1 and replays the access. It sits between the memory stage, the L1 tag compare, the L2 and the main memory interface. It drives the `l1_miss`, `l2_miss`, `cache_busy` and `mem_stall` inputs that the hazard unit turns into pipeline stalls and flushes.

## Interface
- `ADDR_WIDTH`, 32, width of byte addresses.
- `LINE_OFFSET_BITS`, 4, log2 of line size in bytes; the low bits are zeroed on `l2_addr`/`mem_addr`.
- `FILL_CYCLES`, 2, cycles `l1_fill` is held to write one line into L1 (≥1).
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  memory stage holds a load or store.
- `req_write`  in  1  1 = store (write-allocate, same miss flow as loads).
- `req_addr`  in  ADDR_WIDTH  byte address of the access.
- `l1_hit`  in  1  combinational L1 tag match for `req_addr`.
- `l2_req`  out  1  L2 lookup request, held until `l2_ack`.
- `l2_addr`  out  ADDR_WIDTH  line-aligned miss address.
- `l2_ack`  in  1  L2 lookup complete; `l2_hit` is valid this cycle.
- `l2_hit`  in  1  line present in L2.
- `mem_req`  out  1  main memory line read, held until `mem_ack`.
- `mem_addr`  out  ADDR_WIDTH  line-aligned miss address.
- `mem_ack`  in  1  main memory line data valid.
- `l1_fill`  out  1  write the returned line into L1.
- `fill_src`  out  1  line source: 0 = L2, 1 = main memory.
- `l2_fill`  out  1  one-cycle pulse to write the memory line into L2.
- `l1_miss`, `l2_miss`, `cache_busy`, `mem_stall`  out  1 each  stall causes to the hazard unit.
- `l1_miss_count`, `l2_miss_count`  out  32 each  performance counters (see Configuration).

## Operation
- The FSM has five states: IDLE, L2_REQ, MEM_REQ, FILL and REPLAY.
- **IDLE:**
  - On `req_valid && !l1_hit`, register the line address and go to L2_REQ.
  - In that same cycle `l1_miss` is driven combinationally high.
- **L2_REQ:**
  - `l2_req=1`.
  - On `l2_ack && l2_hit`: go to FILL with `fill_src=0`.
  - On `l2_ack && !l2_hit`: go to MEM_REQ.
- **MEM_REQ:**
  - `mem_req=1`.
  - On `mem_ack`: go to FILL with `fill_src=1` and `l2_fill=1` for that one cycle.
- **FILL:**
  - `l1_fill=1` and `cache_busy=1`.
  - A down-counter loaded with `FILL_CYCLES-1` on entry; leave FILL when it reaches 0.
  - Then go to REPLAY.
- **REPLAY:**
  - `mem_stall=1` for exactly one cycle while L1 re-looks-up the now-resident line.
  - Then return to IDLE.
- **Output map:**
  - `l1_miss` = IDLE miss detect, or state in {L2_REQ, MEM_REQ}.
  - `l2_miss` = state MEM_REQ.
  - `cache_busy` = FILL.
  - `mem_stall` = REPLAY.
  - `fill_src` is registered and holds until the next miss.
- While the FSM is outside IDLE:
  - `req_valid`, `req_addr` and `l1_hit` are ignored; the pipeline is stalled and the sequence always completes.
  - `l2_ack`/`mem_ack` outside their own state are ignored.
- `l2_addr`/`mem_addr` = registered `req_addr` with the low `LINE_OFFSET_BITS` cleared. They are stable from entry to L2_REQ until IDLE.
- A hit in IDLE produces no outputs and no state change.

## Timing
- **Reset:**
  - Asynchronous reset forces IDLE, counters to 0, and all registered outputs to 0 (including `fill_src`).
  - With `req_valid=0`, every output is 0.
  - Reset asserted mid-sequence abandons the request: no `l1_fill` and no `l2_fill` follow.
- **L2 hit latency:**
  - Ack k cycles after `l2_req` rises (k≥1).
  - Miss cycle 1 + L2_REQ k + FILL `FILL_CYCLES` + REPLAY 1.
- **L2 miss latency:** additionally adds MEM_REQ cycles up to and including the `mem_ack` cycle.
- **Same-cycle acks:** `l2_ack` in the same cycle as `l2_req` first rises is legal and counts as k=1.
- **Back-to-back misses:** after REPLAY the next miss may be detected in the very next IDLE cycle.

## Configuration
- `CACHE_MISS_PERF_EN` defined:
  - `l1_miss_count` increments on each IDLE→L2_REQ transition.
  - `l2_miss_count` increments on each L2_REQ→MEM_REQ transition.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- Not defined: both counter ports are tied to 0 and no counter flops are built.

## Test plan
- Reset with `req_valid=1`, `l1_hit=0` held -> every output stays 0 while `rst_n=0`. The first miss is detected on the cycle after release.
- Hit: `req_valid=1`, `l1_hit=1` for 10 cycles -> no output ever asserts and the FSM stays in IDLE.
- L2 hit: miss at `req_addr=0x0000_1234`, `l2_ack`+`l2_hit` 3 cycles later ->
  - `l2_addr=0x0000_1230`;
  - `l1_miss` high for 4 cycles;
  - `l1_fill`/`cache_busy` high 2 cycles with `fill_src=0`;
  - `mem_stall` 1 cycle;
  - 7 cycles total.
- L2 miss: `l2_ack` with `l2_hit=0` after 2 cycles, `mem_ack` after 5 more ->
  - `l2_miss` high 5 cycles;
  - `l2_fill` pulses once with `fill_src=1`;
  - with the macro on, both counters read 1.
- Reset asserted in MEM_REQ -> `mem_req` drops immediately, no fill ever occurs, and the FSM is in IDLE after release.
- Spurious `mem_ack` in IDLE and `l2_ack` in FILL -> ignored, with no state or output change.
